rx_deser_fifo: RTL and testbench

Serial-to-parallel receive buffer, successor to the single-word rx shift buffer. Serial bits are assembled into WORD_SIZE-bit words with selectable bit order. Each completed word is pushed into a DEPTH-word FIFO, which a consumer drains through a show-ahead valid/read handshake. Sits between the serial line front-end (bit strobe) and the parallel datapath consumer. Adds fill level, overflow detection and flush.

---
 rtl/rx_deser_fifo.sv | 93 +++++++++
 tb/tb_rx_deser_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deser_fifo.sv
// Serial-to-parallel receive buffer: assembles serial bits into words and queues
// them in a show-ahead FIFO with fill level, sticky overflow and synchronous flush.
module rx_deser_fifo #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         data_serial_wr_en,
  input  logic                         data_serial_in,
  input  logic                         data_parallel_rd_enable,
  output logic [WORD_SIZE-1:0]         data_parallel_out,
  output logic                         data_parallel_valid,
  output logic                         buffer_full,
  output logic [$clog2(DEPTH+1)-1:0]   word_count,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(WORD_SIZE);
  localparam int PW = $clog2(DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE-1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WORD_SIZE-1:0] asm_q;
  logic [WORD_SIZE-1:0] asm_next;
  logic [BW-1:0]        bit_cnt;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic                 word_done;
  logic                 do_pop;
  logic                 do_push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The push candidate includes the bit sampled this cycle, so it comes from asm_next.
  always_comb begin
    asm_next = asm_q;
    if (MSB_FIRST) asm_next = {asm_q[WORD_SIZE-2:0], data_serial_in};
    else           asm_next = {data_serial_in, asm_q[WORD_SIZE-1:1]};
  end

  assign word_done = data_serial_wr_en && (bit_cnt == LAST_BIT);
  assign do_pop    = data_parallel_rd_enable && data_parallel_valid;
  // A pop in the same cycle frees the slot the write lands in, even when full.
  assign do_push   = word_done && ((word_count < FULL_CNT) || do_pop);

  assign data_parallel_valid = (word_count != '0);
  assign buffer_full         = (word_count == FULL_CNT);
  assign data_parallel_out   = data_parallel_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!flush && do_push) mem[wr_ptr] <= asm_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q      <= '0;
      bit_cnt    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (flush) begin
      asm_q      <= '0;
      bit_cnt    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (data_serial_wr_en) begin
        asm_q   <= asm_next;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (word_done && !do_push) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   word_count <= word_count + 1'b1;
        2'b01:   word_count <= word_count - 1'b1;
        default: word_count <= word_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_deser_fifo.sv
// Bench for rx_deser_fifo: an LSB-first and an MSB-first instance share stimulus and
// are checked every cycle against a queue-based model plus literal expectations.
module tb_rx_deser_fifo;

  localparam int W = 8;
  localparam int D = 4;

  logic clk;
  logic reset;
  logic flush;
  logic wr_en;
  logic din;
  logic rd_en;

  logic [W-1:0] out0, out1;
  logic         valid0, valid1, full0, full1, ovf0, ovf1;
  logic [2:0]   cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  rx_deser_fifo #(.WORD_SIZE(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .flush(flush),
    .data_serial_wr_en(wr_en), .data_serial_in(din),
    .data_parallel_rd_enable(rd_en),
    .data_parallel_out(out0), .data_parallel_valid(valid0),
    .buffer_full(full0), .word_count(cnt0), .overflow(ovf0)
  );

  rx_deser_fifo #(.WORD_SIZE(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .flush(flush),
    .data_serial_wr_en(wr_en), .data_serial_in(din),
    .data_parallel_rd_enable(rd_en),
    .data_parallel_out(out1), .data_parallel_valid(valid1),
    .buffer_full(full1), .word_count(cnt1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words as bit positions filled by arrival index, FIFOs as queues.
  logic [W-1:0] q_lsb[$];
  logic [W-1:0] q_msb[$];
  logic [W-1:0] m_lsb, m_msb;
  int           m_cnt;
  logic         m_ovf;

  task automatic model_clear();
    q_lsb.delete();
    q_msb.delete();
    m_lsb = '0;
    m_msb = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    bit pop;
    bit done;
    if (flush) begin
      model_clear();
      return;
    end
    pop  = rd_en && (q_lsb.size() > 0);
    done = wr_en && (m_cnt == W-1);
    if (wr_en) begin
      m_lsb[m_cnt]     = din;
      m_msb[W-1-m_cnt] = din;
    end
    if (pop) begin
      void'(q_lsb.pop_front());
      void'(q_msb.pop_front());
    end
    if (done) begin
      if (q_lsb.size() < D) begin
        q_lsb.push_back(m_lsb);
        q_msb.push_back(m_msb);
      end else begin
        m_ovf = 1'b1;
      end
      m_cnt = 0;
    end else if (wr_en) begin
      m_cnt++;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else       model_edge();
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("valid_lsb", 32'(valid0), 32'(q_lsb.size() > 0));
      check("valid_msb", 32'(valid1), 32'(q_msb.size() > 0));
      check("count_lsb", 32'(cnt0), 32'(q_lsb.size()));
      check("count_msb", 32'(cnt1), 32'(q_msb.size()));
      check("full_lsb", 32'(full0), 32'(q_lsb.size() == D));
      check("ovf_lsb", 32'(ovf0), 32'(m_ovf));
      check("ovf_msb", 32'(ovf1), 32'(m_ovf));
      if (q_lsb.size() > 0) begin
        check("head_lsb", 32'(out0), 32'(q_lsb[0]));
        check("head_msb", 32'(out1), 32'(q_msb[0]));
      end
    end
  end

  // Inputs change just after a falling edge and are held across the next rising edge.
  task automatic cyc(input logic w, input logic d, input logic r, input logic f);
    wr_en = w;
    din   = d;
    rd_en = r;
    flush = f;
    @(negedge clk);
    wr_en = 1'b0;
    din   = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic pop_last);
    for (int i = 0; i < W; i++) cyc(1'b1, w[i], pop_last && (i == W-1), 1'b0);
  endtask

  task automatic pop_chk(input string name, input logic [W-1:0] exp);
    check(name, 32'(out0), 32'(exp));
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    wr_en = 1'b0;
    din   = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_out", 32'(out0), 32'd0);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_count", 32'(cnt0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Bits 1,0,1,1,0,0,0,0
    send_word(8'h0D, 1'b0);
    check("t1_out_lsb", 32'(out0), 32'h0D);
    check("t2_out_msb", 32'(out1), 32'hB0);
    check("t1_valid", 32'(valid0), 32'd1);
    check("t1_count", 32'(cnt0), 32'd1);
    pop_chk("t1_pop", 8'h0D);
    check("t1_empty", 32'(valid0), 32'd0);

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b0);
    check("t3_full", 32'(full0), 32'd1);
    check("t3_count", 32'(cnt0), 32'd4);
    check("t3_no_ovf_yet", 32'(ovf0), 32'd0);
    send_word(8'h05, 1'b0);
    check("t3_ovf", 32'(ovf0), 32'd1);
    check("t3_count_after", 32'(cnt0), 32'd4);
    for (int i = 1; i <= 4; i++) pop_chk("t3_pop", 8'(i));
    check("t3_empty", 32'(valid0), 32'd0);
    check("t3_ovf_sticky", 32'(ovf0), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_no_underflow", 32'(cnt0), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Push into a full FIFO in the same cycle as a pop
    for (int i = 1; i <= 4; i++) send_word(8'(i), 1'b0);
    send_word(8'h05, 1'b1);
    check("t4_no_ovf", 32'(ovf0), 32'd0);
    check("t4_count", 32'(cnt0), 32'd4);
    for (int i = 2; i <= 5; i++) pop_chk("t4_pop", 8'(i));
    check("t4_empty", 32'(valid0), 32'd0);

    // Flush mid-word with count=2 and overflow set; a bit strobed during flush is dropped
    for (int i = 0; i < 5; i++) send_word(8'h10 + 8'(i), 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_pre_count", 32'(cnt0), 32'd2);
    check("t5_pre_ovf", 32'(ovf0), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("t5_count", 32'(cnt0), 32'd0);
    check("t5_valid", 32'(valid0), 32'd0);
    check("t5_ovf", 32'(ovf0), 32'd0);
    send_word(8'h96, 1'b0);
    check("t5_word_lsb", 32'(out0), 32'h96);
    check("t5_word_msb", 32'(out1), 32'h69);
    check("t5_count_after", 32'(cnt0), 32'd1);

    // Asynchronous reset between edges, mid-word
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("t6_out", 32'(out0), 32'd0);
    check("t6_valid", 32'(valid0), 32'd0);
    check("t6_count", 32'(cnt0), 32'd0);
    check("t6_full", 32'(full0), 32'd0);
    check("t6_ovf", 32'(ovf0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_word(8'hC1, 1'b0);
    check("t6_word_lsb", 32'(out0), 32'hC1);
    check("t6_word_msb", 32'(out1), 32'h83);
    check("t6_count_after", 32'(cnt0), 32'd1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
